json_byte_lexer: RTL
====================

# json_byte_lexer

Streaming hardware tokenizer that sits directly upstream of the JSON decoder. It accepts a JSON document as a byte stream, skips whitespace, and emits one token per lexical element: punctuation, string, number, literal, end, or error. Each token carries its start byte offset and length. The decoder builds values from these tokens and uses the offsets in its error reports. The lexer does not check nesting or grammar; that is the decoder's job.

## Interface
Parameters:
- OFFSET_W, 16, width of the byte-offset counter and of tok_offset.
- LEN_W, 16, width of tok_len.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte (ASCII/UTF-8).
- in_last  in  1  marks the final byte of the document.
- tok_valid  out  1  token valid (registered).
- tok_ready  in  1  downstream accepts the token.
- tok_kind  out  4  0 LBRACE, 1 RBRACE, 2 LBRACKET, 3 RBRACKET, 4 COLON, 5 COMMA, 6 STRING, 7 NUMBER, 8 TRUE, 9 FALSE, 10 NULL, 11 END, 15 ERROR.
- tok_offset  out  OFFSET_W  offset of the token's first byte (for ERROR: the offending byte).
- tok_len  out  LEN_W  token length in bytes; STRING includes both quotes; END and ERROR are 0.
- tok_err  out  2  0 NONE, 1 INVALID_CHAR, 2 BAD_LITERAL, 3 UNEXPECTED_END; nonzero only when tok_kind is ERROR.

## Operation
- One-deep output register. A slot is free when !tok_valid || tok_ready; a pop and a load in the same cycle are allowed.
- in_ready = slot free && state != END_PEND. In ERROR state in_ready is 1 so the rest of the document drains.
- Byte offset counter: increments on every accepted byte, wraps modulo 2^OFFSET_W, and clears after the in_last byte is accepted.
- Length counter saturates at 2^LEN_W-1.

States:
- IDLE:
  - Whitespace (0x20, 0x09, 0x0A, 0x0D) is skipped.
  - { } [ ] : , each emit a 1-byte token.
  - `"` goes to STRING.
  - '-' or 0-9 goes to NUMBER.
  - 't', 'f', 'n' go to LITERAL; the expected word is latched and the match index is set to 1.
  - Any other byte emits ERROR/INVALID_CHAR and goes to ERROR.
- STRING:
  - `"` emits STRING and returns to IDLE.
  - '\' goes to STRING_ESC.
  - A byte < 0x20 emits ERROR/INVALID_CHAR.
- STRING_ESC: any byte ≥ 0x20 returns to STRING (the escape is not validated); a byte < 0x20 emits ERROR/INVALID_CHAR.
- NUMBER:
  - Bytes 0-9 + - . e E are consumed.
  - Any other byte is NOT consumed; in_ready is 0 that cycle, a combinational path from in_data. NUMBER is emitted and the state returns to IDLE, which processes the byte next cycle.
- LITERAL:
  - Each byte must match the expected character at the match index; a mismatch emits ERROR/BAD_LITERAL at that byte.
  - On the final character, emit TRUE/FALSE/NULL (length 4/5/4) and return to IDLE.
- END_PEND: load END (offset = document length mod 2^OFFSET_W) when the slot is free, then go to IDLE.
- ERROR: discard bytes until in_last is accepted, then go to IDLE. No END token is emitted for an errored document.

End of document (in_last accepted):
- In IDLE, or a byte that completes a token: process the byte normally, then go to END_PEND.
- In NUMBER with a number character: emit NUMBER including that byte, then END_PEND.
- In STRING, STRING_ESC, or LITERAL without completing the token: emit ERROR/UNEXPECTED_END at that byte's offset and return to IDLE.

## Timing
- Reset values: tok_valid=0, tok_kind=0, tok_offset=0, tok_len=0, tok_err=0, state IDLE, counters 0. in_ready is 1 in the first cycle after reset.
- Reset mid-document discards all state and any pending token.
- Latency: token valid the cycle after its final byte is accepted. NUMBER is valid the cycle after its terminator is presented.
- Throughput: 1 byte/clk with tok_ready held high. Exceptions:
  - a number terminator costs one extra cycle;
  - END costs one cycle with in_ready=0.
- Output stability: tok_* hold stable while tok_valid && !tok_ready.

## Test plan
- `{"a":12}` with in_last on '}' -> LBRACE@0 len1, STRING@1 len3, COLON@4, NUMBER@5 len2, RBRACE@7, END@8.
- ` [true, null ,-3.5e2]` (leading space) -> LBRACKET@1, TRUE@2 len4, COMMA@6, NULL@8 len4, COMMA@13, NUMBER@14 len6, RBRACKET@20, END@21.
- `"x\"y"` -> STRING@0 len6. `"a<0x01>"` -> ERROR INVALID_CHAR@2; subsequent bytes are drained and no END follows.
- `tru!` -> ERROR BAD_LITERAL@3. `42` with in_last on '2' -> NUMBER@0 len2 then END@2. `"ab` with in_last -> ERROR UNEXPECTED_END@2.
- Random tok_ready backpressure on the first vector -> identical token sequence, no drops or duplicates, tok_* stable while stalled.
- rst asserted mid-string, then `[]` -> first tokens LBRACKET@0, RBRACKET@1, END@2.

Source files
------------

// File: rtl/json_byte_lexer.sv
// Streaming JSON tokenizer: skips whitespace and emits one token (kind, start
// offset, length, error code) per lexical element through a one-deep output slot.
module json_byte_lexer #(
  parameter int OFFSET_W = 16,
  parameter int LEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                tok_valid,
  input  logic                tok_ready,
  output logic [3:0]          tok_kind,
  output logic [OFFSET_W-1:0] tok_offset,
  output logic [LEN_W-1:0]    tok_len,
  output logic [1:0]          tok_err
);
  localparam logic [3:0] K_LBRACE = 4'd0, K_RBRACE = 4'd1, K_LBRACKET = 4'd2, K_RBRACKET = 4'd3;
  localparam logic [3:0] K_COLON = 4'd4, K_COMMA = 4'd5, K_STRING = 4'd6, K_NUMBER = 4'd7;
  localparam logic [3:0] K_TRUE = 4'd8, K_END = 4'd11, K_ERROR = 4'd15;
  localparam logic [1:0] E_NONE = 2'd0, E_INVALID = 2'd1, E_BAD_LIT = 2'd2, E_UNEXP_END = 2'd3;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_STRING, S_STRING_ESC, S_NUMBER, S_LITERAL, S_END_PEND, S_ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [OFFSET_W-1:0] offset_reg, start_reg, end_off_reg;
  logic [LEN_W-1:0]    len_reg, len_inc;
  logic [1:0]          lit_word_reg;  // 0 true, 1 false, 2 null
  logic [2:0]          lit_idx_reg;

  logic       slot_free, accept, num_term;
  logic       is_ws, is_ctrl, is_num_start, is_num_char, is_lit_start, is_punct;
  logic [3:0] punct_kind;
  logic [1:0] lit_word_sel;
  logic [7:0] lit_char;
  logic       lit_final;

  logic                load;
  logic [3:0]          ld_kind;
  logic [OFFSET_W-1:0] ld_off;
  logic [LEN_W-1:0]    ld_len;
  logic [1:0]          ld_err;

  function automatic logic [7:0] lit_expect(input logic [1:0] word, input logic [2:0] idx);
    case ({word, idx})
      5'b00_001: lit_expect = "r";
      5'b00_010: lit_expect = "u";
      5'b00_011: lit_expect = "e";
      5'b01_001: lit_expect = "a";
      5'b01_010: lit_expect = "l";
      5'b01_011: lit_expect = "s";
      5'b01_100: lit_expect = "e";
      5'b10_001: lit_expect = "u";
      5'b10_010: lit_expect = "l";
      5'b10_011: lit_expect = "l";
      default:   lit_expect = 8'h00;
    endcase
  endfunction

  // Byte classification
  always_comb begin
    is_punct   = 1'b1;
    punct_kind = K_LBRACE;
    case (in_data)
      "{":     punct_kind = K_LBRACE;
      "}":     punct_kind = K_RBRACE;
      "[":     punct_kind = K_LBRACKET;
      "]":     punct_kind = K_RBRACKET;
      ":":     punct_kind = K_COLON;
      ",":     punct_kind = K_COMMA;
      default: is_punct = 1'b0;
    endcase
  end

  assign is_ws        = (in_data == 8'h20) || (in_data == 8'h09) || (in_data == 8'h0A) || (in_data == 8'h0D);
  assign is_ctrl      = (in_data < 8'h20);
  assign is_num_start = (in_data == "-") || (in_data >= "0" && in_data <= "9");
  assign is_num_char  = is_num_start || (in_data == "+") || (in_data == ".") || (in_data == "e") || (in_data == "E");
  assign is_lit_start = (in_data == "t") || (in_data == "f") || (in_data == "n");
  assign lit_word_sel = (in_data == "f") ? 2'd1 : (in_data == "n") ? 2'd2 : 2'd0;
  assign lit_char     = lit_expect(lit_word_reg, lit_idx_reg);
  assign lit_final    = (lit_word_reg == 2'd1) ? (lit_idx_reg == 3'd4) : (lit_idx_reg == 3'd3);
  assign len_inc      = (len_reg == LEN_MAX) ? len_reg : len_reg + LEN_W'(1);

  assign slot_free = !tok_valid || tok_ready;
  // A non-number byte ends a number without being consumed.
  assign num_term  = (state_reg == S_NUMBER) && in_valid && !is_num_char;
  assign in_ready  = slot_free && (state_reg != S_END_PEND) && !num_term;
  assign accept    = in_valid && in_ready;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) begin
        if (is_ws || is_punct) state_next = in_last ? S_END_PEND : S_IDLE;
        else if (in_data == "\"") state_next = in_last ? S_IDLE : S_STRING;
        else if (is_num_start) state_next = in_last ? S_END_PEND : S_NUMBER;
        else if (is_lit_start) state_next = in_last ? S_IDLE : S_LITERAL;
        else state_next = in_last ? S_IDLE : S_ERROR;
      end
      S_STRING: if (accept) begin
        if (is_ctrl) state_next = in_last ? S_IDLE : S_ERROR;
        else if (in_data == "\"") state_next = in_last ? S_END_PEND : S_IDLE;
        else if (in_data == "\\") state_next = in_last ? S_IDLE : S_STRING_ESC;
        else state_next = in_last ? S_IDLE : S_STRING;
      end
      S_STRING_ESC: if (accept) begin
        if (is_ctrl) state_next = in_last ? S_IDLE : S_ERROR;
        else state_next = in_last ? S_IDLE : S_STRING;
      end
      S_NUMBER: begin
        if (num_term && slot_free) state_next = S_IDLE;
        else if (accept) state_next = in_last ? S_END_PEND : S_NUMBER;
      end
      S_LITERAL: if (accept) begin
        if (in_data != lit_char) state_next = in_last ? S_IDLE : S_ERROR;
        else if (lit_final) state_next = in_last ? S_END_PEND : S_IDLE;
        else state_next = in_last ? S_IDLE : S_LITERAL;
      end
      S_END_PEND: if (slot_free) state_next = S_IDLE;
      S_ERROR:    if (accept && in_last) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Token load decode
  always_comb begin
    load    = 1'b0;
    ld_kind = K_END;
    ld_off  = start_reg;
    ld_len  = '0;
    ld_err  = E_NONE;
    case (state_reg)
      S_IDLE: if (accept && !is_ws) begin
        ld_off = offset_reg;
        if (is_punct) begin
          load = 1'b1; ld_kind = punct_kind; ld_len = LEN_W'(1);
        end else if (is_num_start) begin
          load = in_last; ld_kind = K_NUMBER; ld_len = LEN_W'(1);
        end else if (in_data == "\"" || is_lit_start) begin
          load = in_last; ld_kind = K_ERROR; ld_err = E_UNEXP_END;
        end else begin
          load = 1'b1; ld_kind = K_ERROR; ld_err = E_INVALID;
        end
      end
      S_STRING, S_STRING_ESC: if (accept) begin
        if (is_ctrl) begin
          load = 1'b1; ld_kind = K_ERROR; ld_err = E_INVALID; ld_off = offset_reg;
        end else if (state_reg == S_STRING && in_data == "\"") begin
          load = 1'b1; ld_kind = K_STRING; ld_len = len_inc;
        end else if (in_last) begin
          load = 1'b1; ld_kind = K_ERROR; ld_err = E_UNEXP_END; ld_off = offset_reg;
        end
      end
      S_NUMBER: begin
        if (num_term && slot_free) begin
          load = 1'b1; ld_kind = K_NUMBER; ld_len = len_reg;
        end else if (accept && in_last) begin
          load = 1'b1; ld_kind = K_NUMBER; ld_len = len_inc;
        end
      end
      S_LITERAL: if (accept) begin
        if (in_data != lit_char) begin
          load = 1'b1; ld_kind = K_ERROR; ld_err = E_BAD_LIT; ld_off = offset_reg;
        end else if (lit_final) begin
          load = 1'b1; ld_kind = K_TRUE + {2'b00, lit_word_reg}; ld_len = len_inc;
        end else if (in_last) begin
          load = 1'b1; ld_kind = K_ERROR; ld_err = E_UNEXP_END; ld_off = offset_reg;
        end
      end
      S_END_PEND: if (slot_free) begin
        load = 1'b1; ld_kind = K_END; ld_off = end_off_reg;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      offset_reg   <= '0;
      start_reg    <= '0;
      end_off_reg  <= '0;
      len_reg      <= '0;
      lit_word_reg <= 2'd0;
      lit_idx_reg  <= 3'd0;
      tok_valid    <= 1'b0;
      tok_kind     <= 4'd0;
      tok_offset   <= '0;
      tok_len      <= '0;
      tok_err      <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        offset_reg <= in_last ? '0 : offset_reg + OFFSET_W'(1);
        if (in_last) end_off_reg <= offset_reg + OFFSET_W'(1);
        if (state_reg == S_IDLE) begin
          start_reg    <= offset_reg;
          len_reg      <= LEN_W'(1);
          lit_word_reg <= lit_word_sel;
          lit_idx_reg  <= 3'd1;
        end else begin
          len_reg     <= len_inc;
          lit_idx_reg <= lit_idx_reg + 3'd1;
        end
      end
      if (load) begin
        tok_valid  <= 1'b1;
        tok_kind   <= ld_kind;
        tok_offset <= ld_off;
        tok_len    <= ld_len;
        tok_err    <= ld_err;
      end else if (tok_ready) begin
        tok_valid <= 1'b0;
      end
    end
  end
endmodule
